// File: rtl/ipsxe_floating_point_sqrt_core_v1_0_pkg.sv
// Shared definitions for the floating-point square-root core:
// special-case codes from the upstream classifier, FSM encoding and exponent bias.
package ipsxe_floating_point_sqrt_core_v1_0_pkg;

  localparam logic [1:0] SPECIAL_NAN  = 2'd0;
  localparam logic [1:0] SPECIAL_INF  = 2'd1;
  localparam logic [1:0] SPECIAL_ZERO = 2'd2;
  localparam logic [1:0] SPECIAL_NUM  = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } sqrt_state_e;

  function automatic int exp_bias(input int exponent_size);
    return (1 << (exponent_size - 1)) - 1;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_sqrt_core_v1_0_if.sv
// Operand/result handshake bundle for the square-root core.
// The slave modport is the core's view; master is the upstream/downstream view.
interface ipsxe_floating_point_sqrt_core_v1_0_if #(
  parameter int SIZE          = 64,
  parameter int EXPONENT_SIZE = 11,
  parameter int MANTISSA_SIZE = 52
);
  logic                     i_valid;
  logic                     o_ready;
  logic                     i_sign;
  logic [EXPONENT_SIZE-1:0] i_exponent;
  logic [MANTISSA_SIZE-1:0] i_mantissa;
  logic [1:0]               i_state_special;
  logic                     o_valid;
  logic                     i_ready;
  logic [SIZE-1:0]          o_result;

  modport slave (
    input  i_valid, i_sign, i_exponent, i_mantissa, i_state_special, i_ready,
    output o_ready, o_valid, o_result
  );

  modport master (
    output i_valid, i_sign, i_exponent, i_mantissa, i_state_special, i_ready,
    input  o_ready, o_valid, o_result
  );
endinterface

// File: rtl/ipsxe_floating_point_lzc_v1_0.sv
// Combinational leading-zero counter; returns WIDTH when the input is all zeros.
module ipsxe_floating_point_lzc_v1_0 #(
  parameter int WIDTH = 52,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_sqrt_core_v1_0.sv
// Sequential IEEE-754 square root: special-case bypass, normalisation, radix-2
// restoring recurrence (one result bit per cycle) and round-to-nearest-even.
module ipsxe_floating_point_sqrt_core_v1_0
  import ipsxe_floating_point_sqrt_core_v1_0_pkg::*;
#(
  parameter int SIZE          = 64,
  parameter int EXPONENT_SIZE = 11,
  parameter int MANTISSA_SIZE = 52
) (
  input logic                                  i_aclk,
  input logic                                  i_aresetn,
  ipsxe_floating_point_sqrt_core_v1_0_if.slave sqrt_if
);

  localparam int N     = MANTISSA_SIZE + 2;
  localparam int RAD_W = 2 * N;
  localparam int REM_W = N + 2;
  localparam int EW    = EXPONENT_SIZE + 2;
  localparam int CNT_W = $clog2(N);
  localparam int LZ_W  = $clog2(MANTISSA_SIZE + 1);
  localparam int BIAS  = exp_bias(EXPONENT_SIZE);

  localparam logic signed [EW-1:0] EXP_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] DEN_EXP  = EW'(-BIAS);
  localparam logic signed [EW-1:0] ONE_S    = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S   = EW'(0);
  localparam logic [SIZE-1:0] QNAN = {1'b0, {EXPONENT_SIZE{1'b1}}, 1'b1, {(MANTISSA_SIZE-1){1'b0}}};
  localparam logic [SIZE-1:0] PINF = {1'b0, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};

  sqrt_state_e              state_q, state_d;
  logic [EXPONENT_SIZE-1:0] exp_in_q, exp_in_d;
  logic [MANTISSA_SIZE-1:0] mant_q, mant_d;
  logic [RAD_W-1:0]         rad_q, rad_d;
  logic [REM_W-1:0]         rem_q, rem_d;
  logic [N-1:0]             root_q, root_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [EW-1:0]     res_exp_q, res_exp_d;
  logic [SIZE-1:0]          result_q, result_d;

  logic [LZ_W-1:0]          lz;
  logic [MANTISSA_SIZE:0]   sig;
  logic signed [EW-1:0]     exp_unb, exp_adj, exp_fin;
  logic [REM_W-1:0]         rem_sh, trial;
  logic [MANTISSA_SIZE:0]   frac_rnd;
  logic                     unused_bits;

  // Fraction = bits below the integer bit; guard = root[0]; carry lands in bit MANTISSA_SIZE.
  function automatic logic [MANTISSA_SIZE:0] round_rne(input logic [N-1:0] root,
                                                       input logic       sticky);
    logic inc;
    inc = root[0] & (sticky | root[1]);
    return {1'b0, root[N-2:1]} + {{MANTISSA_SIZE{1'b0}}, inc};
  endfunction

  ipsxe_floating_point_lzc_v1_0 #(
    .WIDTH (MANTISSA_SIZE),
    .CNT_W (LZ_W)
  ) u_lzc (
    .data_i  (mant_q),
    .count_o (lz)
  );

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q   <= IDLE;
      exp_in_q  <= '0;
      mant_q    <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      res_exp_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      exp_in_q  <= exp_in_d;
      mant_q    <= mant_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      res_exp_q <= res_exp_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sqrt_if.i_valid)
                 state_d = (sqrt_if.i_state_special == SPECIAL_NUM) ? PREP : DONE;
      PREP:    state_d = ITER;
      ITER:    if (cnt_q == CNT_W'(N - 1)) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (sqrt_if.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sqrt_if.o_ready  = (state_q == IDLE);
    sqrt_if.o_valid  = (state_q == DONE);
    sqrt_if.o_result = result_q;
  end

  always_comb begin
    exp_in_d  = exp_in_q;
    mant_d    = mant_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    res_exp_d = res_exp_q;
    result_d  = result_q;
    sig       = '0;
    exp_unb   = '0;
    exp_adj   = '0;
    exp_fin   = '0;
    rem_sh    = '0;
    trial     = '0;
    frac_rnd  = '0;
    case (state_q)
      IDLE: if (sqrt_if.i_valid) begin
        exp_in_d = sqrt_if.i_exponent;
        mant_d   = sqrt_if.i_mantissa;
        case (sqrt_if.i_state_special)
          SPECIAL_NAN:  result_d = QNAN;
          SPECIAL_INF:  result_d = PINF;
          SPECIAL_ZERO: result_d = {sqrt_if.i_sign, {(SIZE-1){1'b0}}};
          default:      ;
        endcase
      end
      PREP: begin
        // Denormal: shift by lz+1 so the first set bit becomes the hidden bit.
        if (exp_in_q == '0) begin
          sig     = ({1'b0, mant_q} << lz) << 1;
          exp_unb = DEN_EXP - $signed(EW'(lz));
        end else begin
          sig     = {1'b1, mant_q};
          exp_unb = $signed({2'b00, exp_in_q}) - EXP_BIAS;
        end
        if (exp_unb[0]) begin
          rad_d   = {sig, {(N+1){1'b0}}};
          exp_adj = exp_unb - ONE_S;
        end else begin
          rad_d   = {1'b0, sig, {N{1'b0}}};
          exp_adj = exp_unb;
        end
        res_exp_d = (exp_adj >>> 1) + EXP_BIAS;
        rem_d     = '0;
        root_d    = '0;
        cnt_d     = '0;
      end
      ITER: begin
        // Remainder never exceeds 2*root, so its top two bits are free to drop here.
        rem_sh = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
        trial  = {root_q, 2'b01};
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[N-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[N-2:0], 1'b0};
        end
        rad_d = {rad_q[RAD_W-3:0], 2'b00};
        cnt_d = cnt_q + CNT_W'(1);
      end
      ROUND: begin
        frac_rnd = round_rne(root_q, |rem_q);
        exp_fin  = res_exp_q + (frac_rnd[MANTISSA_SIZE] ? ONE_S : ZERO_S);
        result_d = {1'b0, exp_fin[EXPONENT_SIZE-1:0], frac_rnd[MANTISSA_SIZE-1:0]};
      end
      default: ;
    endcase
  end

  assign unused_bits = &{1'b0, root_q[N-1], exp_fin[EW-1:EXPONENT_SIZE]};

endmodule
